mux_scan_ctrl: RTL and testbench

Scan controller that sits directly upstream of the 2-bit 4:1 data-select mux. It drives the mux select `S` and active-low enable `EN`, stepping round-robin through the enabled channels with a fixed dwell per channel. It also captures the mux output `Y` returned on `y_in` into a per-channel result register, so that one frame yields a snapshot of all four enabled 2-bit inputs.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_ctrl_chan_next_sel.sv | 29 ++
 rtl/mux_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef logic [1:0] chan_idx_t;

    localparam int DWELL_DEFAULT = 4;
    localparam int SLOT_W        = 2;
    localparam int NUM_CH        = 4;

endpackage

// File: rtl/mux_scan_ctrl_chan_next_sel.sv
// Channel picker: next enabled channel above the current one, wrap flag,
// and lowest enabled channel of a mask.
module chan_next_sel
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  chan_idx_t         cur_i,
    output chan_idx_t         nxt_o,
    output logic              wrap_o,
    output chan_idx_t         low_o
);

    // Descending scans so the last hit is the lowest qualifying channel.
    always_comb begin
        nxt_o  = cur_i;
        wrap_o = 1'b1;
        low_o  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                nxt_o  = chan_idx_t'(i);
                wrap_o = 1'b0;
            end
            if (mask_i[i]) begin
                low_o = chan_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan of the enabled mux channels with fixed dwell; captures the
// returned mux output into one 2-bit slot per channel.
//
// state | meaning
// IDLE  | mux disabled (EN=1, S=00), waiting for start with a non-zero mask
// SCAN  | dwelling on channel S; sample y_in on the last dwell cycle
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT,
    parameter int CW    = $clog2(DWELL)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    output logic [1:0] S,
    output logic       EN,
    input  logic [1:0] y_in,
    output logic [7:0] cap,
    output logic       busy,
    output logic       frame_done
);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    chan_idx_t       sel_q, sel_d;
    logic            en_n_q, en_n_d;
    logic [7:0]      cap_q, cap_d;
    logic [3:0]      mask_q, mask_d;
    logic            stop_q, stop_d;
    logic            done_q, done_d;

    chan_idx_t       nxt_adv;
    logic            wrap_adv;
    chan_idx_t       unused_low_adv;
    chan_idx_t       low_new;
    chan_idx_t       unused_nxt_new;
    logic            unused_wrap_new;
    logic            last_dwell;
    logic            halt_req;

    // Advance uses the frame's latched mask; frame start uses the live mask.
    chan_next_sel u_adv (
        .mask_i (mask_q),
        .cur_i  (sel_q),
        .nxt_o  (nxt_adv),
        .wrap_o (wrap_adv),
        .low_o  (unused_low_adv)
    );

    chan_next_sel u_new (
        .mask_i (mask),
        .cur_i  (2'b00),
        .nxt_o  (unused_nxt_new),
        .wrap_o (unused_wrap_new),
        .low_o  (low_new)
    );

    assign last_dwell = (cnt_q == CW'(DWELL - 1));
    // A stop arriving in the final dwell cycle still ends this frame.
    assign halt_req   = stop_q | stop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        cap_d   = cap_q;
        mask_d  = mask_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                sel_d  = '0;
                en_n_d = 1'b1;
                if (start && (mask != 4'b0000)) begin
                    mask_d  = mask;
                    sel_d   = low_new;
                    en_n_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (last_dwell) begin
                    case (sel_q)
                        2'd0:    cap_d[1:0] = y_in;
                        2'd1:    cap_d[3:2] = y_in;
                        2'd2:    cap_d[5:4] = y_in;
                        default: cap_d[7:6] = y_in;
                    endcase
                    cnt_d = '0;
                    if (!wrap_adv) begin
                        sel_d = nxt_adv;
                    end else begin
                        done_d = 1'b1;
                        if (halt_req || (mask == 4'b0000)) begin
                            state_d = IDLE;
                            en_n_d  = 1'b1;
                            sel_d   = '0;
                            stop_d  = 1'b0;
                            if (!halt_req) begin
                                mask_d = mask;
                            end
                        end else begin
                            mask_d = mask;
                            sel_d  = low_new;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            cap_q   <= '0;
            mask_q  <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    assign S          = sel_q;
    assign EN         = en_n_q;
    assign cap        = cap_q;
    assign busy       = (state_q == SCAN);
    assign frame_done = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table-driven first frame plus hand-written
// sequences for stop, empty mask, mid-frame mask change, async reset and DWELL=2.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [3:0] mask;
    logic [1:0] S;
    logic       EN;
    logic [1:0] y_in;
    logic [7:0] cap;
    logic       busy, frame_done;

    logic       start2, stop2;
    logic [3:0] mask2;
    logic [1:0] S2;
    logic       EN2;
    logic [1:0] y_in2;
    logic [7:0] cap2;
    logic       busy2, done2;

    logic [1:0] ch [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Mux model: Y follows the selected channel while enabled.
    assign y_in  = EN  ? 2'b00 : ch[S];
    assign y_in2 = EN2 ? 2'b00 : ch[S2];

    mux_scan_ctrl #(.DWELL(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .S          (S),
        .EN         (EN),
        .y_in       (y_in),
        .cap        (cap),
        .busy       (busy),
        .frame_done (frame_done)
    );

    mux_scan_ctrl #(.DWELL(2)) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .stop       (stop2),
        .mask       (mask2),
        .S          (S2),
        .EN         (EN2),
        .y_in       (y_in2),
        .cap        (cap2),
        .busy       (busy2),
        .frame_done (done2)
    );

    typedef struct {
        int         cyc;
        logic [1:0] s;
        logic       en_n;
        logic       busy;
        logic       done;
        logic [7:0] cap;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int k;

        tbl[0] = '{1,  2'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{4,  2'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{5,  2'd1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[3] = '{8,  2'd1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[4] = '{9,  2'd2, 1'b0, 1'b1, 1'b0, 8'h09};
        tbl[5] = '{12, 2'd2, 1'b0, 1'b1, 1'b0, 8'h09};
        tbl[6] = '{13, 2'd3, 1'b0, 1'b1, 1'b0, 8'h39};
        tbl[7] = '{16, 2'd3, 1'b0, 1'b1, 1'b0, 8'h39};
        tbl[8] = '{17, 2'd0, 1'b0, 1'b1, 1'b1, 8'h39};
        tbl[9] = '{18, 2'd0, 1'b0, 1'b1, 1'b0, 8'h39};

        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mask   = 4'b0000;
        start2 = 1'b0;
        stop2  = 1'b0;
        mask2  = 4'b0000;
        ch[0] = 2'b01; ch[1] = 2'b10; ch[2] = 2'b11; ch[3] = 2'b00;

        nedge(2);
        chk("rst_S", S, 2'd0);
        chk("rst_EN", EN, 1'b1);
        chk("rst_cap", cap, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        nedge(1);

        // Full frame, mask 1111, table-driven.
        mask  = 4'b1111;
        start = 1'b1;
        cyc   = 0;
        foreach (tbl[i]) begin
            while (cyc < tbl[i].cyc) begin
                nedge(1);
                cyc++;
                if (cyc == 1) start = 1'b0;
            end
            chk($sformatf("f1_S_c%0d", cyc), S, tbl[i].s);
            chk($sformatf("f1_EN_c%0d", cyc), EN, tbl[i].en_n);
            chk($sformatf("f1_busy_c%0d", cyc), busy, tbl[i].busy);
            chk($sformatf("f1_done_c%0d", cyc), frame_done, tbl[i].done);
            chk($sformatf("f1_cap_c%0d", cyc), cap, tbl[i].cap);
        end

        // Stop during frame 2 ends it at cycle 33.
        stop = 1'b1;
        nedge(1);
        cyc++;
        stop = 1'b0;
        while (frame_done !== 1'b1 && cyc < 40) begin
            nedge(1);
            cyc++;
        end
        chk("f2_stop_cycle", cyc, 33);
        chk("f2_stop_busy", busy, 1'b0);
        chk("f2_stop_EN", EN, 1'b1);
        chk("f2_stop_S", S, 2'd0);
        chk("f2_stop_cap", cap, 8'h39);

        // mask 0101 with stop mid-frame.
        ch[0] = 2'b10; ch[1] = 2'b11; ch[2] = 2'b00; ch[3] = 2'b11;
        mask  = 4'b0101;
        start = 1'b1;
        nedge(1);
        start = 1'b0;
        chk("m5_S_c1", S, 2'd0);
        chk("m5_EN_c1", EN, 1'b0);
        nedge(4);
        chk("m5_S_c5", S, 2'd2);
        chk("m5_cap_c5", cap, 8'h3A);
        stop = 1'b1;
        nedge(1);
        stop = 1'b0;
        nedge(3);
        chk("m5_done_c9", frame_done, 1'b1);
        chk("m5_busy_c9", busy, 1'b0);
        chk("m5_EN_c9", EN, 1'b1);
        chk("m5_capA", cap[1:0], 2'b10);
        chk("m5_capB_kept", cap[3:2], 2'b10);
        chk("m5_capC", cap[5:4], 2'b00);
        chk("m5_capD_kept", cap[7:6], 2'b00);

        // Start with empty mask is ignored.
        mask  = 4'b0000;
        start = 1'b1;
        nedge(1);
        start = 1'b0;
        chk("m0_busy", busy, 1'b0);
        chk("m0_EN", EN, 1'b1);
        nedge(2);
        chk("m0_busy_late", busy, 1'b0);

        // Single channel D: frame_done every DWELL cycles.
        mask  = 4'b1000;
        start = 1'b1;
        nedge(1);
        start = 1'b0;
        chk("m8_S_c1", S, 2'd3);
        chk("m8_EN_c1", EN, 1'b0);
        chk("m8_busy_c1", busy, 1'b1);
        for (int c = 2; c <= 12; c++) begin
            nedge(1);
            chk($sformatf("m8_done_c%0d", c), frame_done, (c == 5 || c == 9));
            chk($sformatf("m8_S_c%0d", c), S, 2'd3);
        end
        stop = 1'b1;
        nedge(1);
        stop = 1'b0;
        chk("m8_stop_done", frame_done, 1'b1);
        chk("m8_stop_busy", busy, 1'b0);
        chk("m8_stop_EN", EN, 1'b1);
        chk("m8_cap", cap, 8'hCA);

        // Mask change during channel B only affects the next frame.
        ch[0] = 2'b00; ch[1] = 2'b01; ch[2] = 2'b10; ch[3] = 2'b11;
        mask  = 4'b1111;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            nedge(1);
            if (c == 1) start = 1'b0;
            if (c == 6) mask = 4'b0010;
            if (c == 9)  chk("mc_S_c9", S, 2'd2);
            if (c == 13) chk("mc_S_c13", S, 2'd3);
            if (c == 17) begin
                chk("mc_S_c17", S, 2'd1);
                chk("mc_done_c17", frame_done, 1'b1);
                chk("mc_cap_c17", cap, 8'hE4);
            end
            if (c == 18) begin
                ch[1] = 2'b11;
                mask  = 4'b1111;
            end
            if (c == 21) begin
                chk("mc_S_c21", S, 2'd0);
                chk("mc_done_c21", frame_done, 1'b1);
                chk("mc_cap_c21", cap, 8'hEC);
            end
            if (c == 29) chk("mc_S_c29", S, 2'd2);
        end

        // Async reset during channel C dwell, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        chk("ar_S", S, 2'd0);
        chk("ar_EN", EN, 1'b1);
        chk("ar_cap", cap, 8'h00);
        chk("ar_busy", busy, 1'b0);
        chk("ar_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        nedge(1);
        mask  = 4'b0110;
        start = 1'b1;
        nedge(1);
        start = 1'b0;
        chk("ar_new_S", S, 2'd1);
        chk("ar_new_EN", EN, 1'b0);
        chk("ar_new_busy", busy, 1'b1);
        chk("ar_new_cap", cap, 8'h00);
        stop = 1'b1;
        nedge(1);
        stop = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            nedge(1);
            k++;
        end
        chk("ar_stop_idle", busy, 1'b0);

        // DWELL=2 with start and stop held high.
        mask2  = 4'b0011;
        start2 = 1'b1;
        stop2  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nedge(1);
            chk($sformatf("d2_busy_c%0d", c), busy2, !(c == 5 || c == 10));
            chk($sformatf("d2_done_c%0d", c), done2, (c == 5 || c == 10));
            if (c == 3) chk("d2_S_c3", S2, 2'd1);
            if (c == 5) chk("d2_EN_c5", EN2, 1'b1);
            if (c == 6) begin
                chk("d2_S_c6", S2, 2'd0);
                chk("d2_EN_c6", EN2, 1'b0);
            end
        end
        start2 = 1'b0;
        stop2  = 1'b0;
        nedge(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
